// File: rtl/secded_scrub_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// secded_scrub_ctrl_pkg
// Shared types for the SECDED scrub controller.
//   SCRUB_ADDR_W  : address width carried by a scrub entry
//   SCRUB_CW_W    : codeword width (64 data + 8 parity)
//   scrub_entry_t : one queued write-back request {addr, data}
//   ecc_evt_e     : per-word classification of the decoder flags
//   classify_evt  : maps valid/single/double flags onto ecc_evt_e
// -----------------------------------------------------------------------------
package secded_scrub_ctrl_pkg;

   localparam int SCRUB_ADDR_W = 32;
   localparam int SCRUB_CW_W   = 72;

   typedef struct packed {
      logic [SCRUB_ADDR_W-1:0] addr;
      logic [71:0]             data;
   } scrub_entry_t;

   typedef enum logic [1:0] {
      EVT_NONE = 2'd0,
      EVT_CE   = 2'd1,
      EVT_UE   = 2'd2
   } ecc_evt_e;

   // A double error outranks a single error: the word cannot be trusted.
   function automatic ecc_evt_e classify_evt(input logic valid,
                                             input logic single_err,
                                             input logic double_err);
      ecc_evt_e evt;
      if (!valid) begin
         evt = EVT_NONE;
      end else if (double_err) begin
         evt = EVT_UE;
      end else if (single_err) begin
         evt = EVT_CE;
      end else begin
         evt = EVT_NONE;
      end
      return evt;
   endfunction

endpackage

// File: rtl/secded_scrub_ctrl_if.sv
// -----------------------------------------------------------------------------
// secded_scrub_ctrl_if
// Bundles the decoder-side input and the write-back handshake.
//   dec_valid/dec_addr/dec_data/single_error/double_error : decoder outputs
//   wb_valid/wb_ready/wb_addr/wb_data                     : scrub request
// master: environment (decoder + memory controller); slave: scrub controller.
// -----------------------------------------------------------------------------
interface secded_scrub_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              dec_valid;
   logic [ADDR_W-1:0] dec_addr;
   logic [71:0]       dec_data;
   logic              single_error;
   logic              double_error;
   logic              wb_valid;
   logic              wb_ready;
   logic [ADDR_W-1:0] wb_addr;
   logic [71:0]       wb_data;

   modport master (
      output dec_valid, dec_addr, dec_data, single_error, double_error, wb_ready,
      input  wb_valid, wb_addr, wb_data
   );

   modport slave (
      input  dec_valid, dec_addr, dec_data, single_error, double_error, wb_ready,
      output wb_valid, wb_addr, wb_data
   );
endinterface

// File: rtl/secded_scrub_fifo.sv
// -----------------------------------------------------------------------------
// secded_scrub_fifo
// Synchronous FIFO of scrub_entry_t with a registered head.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : request to enqueue push_data (ignored when full without pop)
//   push_data  : entry to enqueue
//   pop        : dequeue the head (ignored when empty)
//   full       : all DEPTH slots occupied
//   empty      : registered; no entry present
//   head       : registered copy of the oldest entry
// -----------------------------------------------------------------------------
module secded_scrub_fifo
   import secded_scrub_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  scrub_entry_t push_data,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output scrub_entry_t head
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   scrub_entry_t     mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_nxt_s;
   logic [PTR_W-1:0] rd_ptr_nxt_s;
   logic             empty_r;
   logic             full_s;
   logic             push_ok_s;
   logic             pop_ok_s;
   scrub_entry_t     head_r;
   scrub_entry_t     head_nxt_s;

   // Pointer arithmetic and look-ahead of the entry that becomes the head.
   always_comb begin
      full_s       = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                     (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
      pop_ok_s     = pop && !empty_r;
      // A simultaneous pop frees a slot, so a full FIFO can still accept.
      push_ok_s    = push && (!full_s || pop_ok_s);
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      if (push_ok_s) begin
         wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_ok_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
      // The new head is the slot being written this cycle when the reader
      // lands on it; otherwise it is already in storage.
      if (push_ok_s && (rd_ptr_nxt_s[IDX_W-1:0] == wr_ptr_r[IDX_W-1:0])) begin
         head_nxt_s = push_data;
      end else begin
         head_nxt_s = mem_r[rd_ptr_nxt_s[IDX_W-1:0]];
      end
   end

   // Storage array write; contents are don't-care while empty, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r[IDX_W-1:0]] <= push_data;
      end
   end

   // Pointers, empty flag and registered head.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         empty_r  <= 1'b1;
         head_r   <= '0;
      end else begin
         wr_ptr_r <= wr_ptr_nxt_s;
         rd_ptr_r <= rd_ptr_nxt_s;
         empty_r  <= (wr_ptr_nxt_s == rd_ptr_nxt_s);
         head_r   <= head_nxt_s;
      end
   end

   assign full  = full_s;
   assign empty = empty_r;
   assign head  = head_r;

endmodule

// File: rtl/secded_scrub_ctrl.sv
// -----------------------------------------------------------------------------
// secded_scrub_ctrl
// Error-handling stage after the SECDED decoder: queues corrected words for
// scrub write-back, counts CE/UE/drop events, captures the first UE address.
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : decoder outputs in, scrub write-back handshake out
//   ce_count     : correctable events (saturating)
//   ue_count     : uncorrectable events (saturating)
//   drop_count   : scrubs lost to a full FIFO (saturating)
//   ue_valid     : ue_addr holds a captured address
//   ue_addr      : first UE address since the last clear
//   irq          : level interrupt, set on any UE or drop
//   clr          : clears counters, ue_valid, ue_addr, irq (events win)
// -----------------------------------------------------------------------------
module secded_scrub_ctrl
   import secded_scrub_ctrl_pkg::*;
#(
   parameter int ADDR_W = SCRUB_ADDR_W,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst,
   secded_scrub_ctrl_if.slave  bus,
   output logic [CNT_W-1:0]    ce_count,
   output logic [CNT_W-1:0]    ue_count,
   output logic [CNT_W-1:0]    drop_count,
   output logic                ue_valid,
   output logic [ADDR_W-1:0]   ue_addr,
   output logic                irq,
   input  logic                clr
);

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == {CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

   ecc_evt_e          evt_s;
   logic              ce_s;
   logic              ue_s;
   logic              pop_s;
   logic              drop_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   scrub_entry_t      push_entry_s;
   scrub_entry_t      head_s;

   logic [CNT_W-1:0]  ce_cnt_r,   ce_cnt_nxt_s,   ce_base_s;
   logic [CNT_W-1:0]  ue_cnt_r,   ue_cnt_nxt_s,   ue_base_s;
   logic [CNT_W-1:0]  drop_cnt_r, drop_cnt_nxt_s, drop_base_s;
   logic              ue_valid_r, ue_valid_nxt_s, ue_valid_base_s;
   logic [ADDR_W-1:0] ue_addr_r,  ue_addr_nxt_s,  ue_addr_base_s;
   logic              irq_r,      irq_nxt_s,      irq_base_s;

   // Decode the flags into one-hot CE/UE strobes and the FIFO controls.
   always_comb begin
      evt_s = classify_evt(bus.dec_valid, bus.single_error, bus.double_error);
      case (evt_s)
         EVT_CE: begin
            ce_s = 1'b1;
            ue_s = 1'b0;
         end
         EVT_UE: begin
            ce_s = 1'b0;
            ue_s = 1'b1;
         end
         EVT_NONE: begin
            ce_s = 1'b0;
            ue_s = 1'b0;
         end
         default: begin
            ce_s = 1'b0;
            ue_s = 1'b0;
         end
      endcase
      pop_s             = !fifo_empty_s && bus.wb_ready;
      drop_s            = ce_s && fifo_full_s && !pop_s;
      push_entry_s.addr = bus.dec_addr;
      push_entry_s.data = bus.dec_data;
   end

   secded_scrub_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (ce_s),
      .push_data (push_entry_s),
      .pop       (pop_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .head      (head_s)
   );

   // Next state of counters, UE capture and irq; clear first, event on top.
   always_comb begin
      if (clr) begin
         ce_base_s       = '0;
         ue_base_s       = '0;
         drop_base_s     = '0;
         ue_valid_base_s = 1'b0;
         ue_addr_base_s  = '0;
         irq_base_s      = 1'b0;
      end else begin
         ce_base_s       = ce_cnt_r;
         ue_base_s       = ue_cnt_r;
         drop_base_s     = drop_cnt_r;
         ue_valid_base_s = ue_valid_r;
         ue_addr_base_s  = ue_addr_r;
         irq_base_s      = irq_r;
      end

      if (ce_s) begin
         ce_cnt_nxt_s = sat_inc(ce_base_s);
      end else begin
         ce_cnt_nxt_s = ce_base_s;
      end

      if (ue_s) begin
         ue_cnt_nxt_s = sat_inc(ue_base_s);
      end else begin
         ue_cnt_nxt_s = ue_base_s;
      end

      if (drop_s) begin
         drop_cnt_nxt_s = sat_inc(drop_base_s);
      end else begin
         drop_cnt_nxt_s = drop_base_s;
      end

      // Only the first UE since the last clear is recorded.
      if (ue_s && !ue_valid_base_s) begin
         ue_valid_nxt_s = 1'b1;
         ue_addr_nxt_s  = bus.dec_addr;
      end else begin
         ue_valid_nxt_s = ue_valid_base_s;
         ue_addr_nxt_s  = ue_addr_base_s;
      end

      irq_nxt_s = irq_base_s || ue_s || drop_s;
   end

   // Status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ce_cnt_r   <= '0;
         ue_cnt_r   <= '0;
         drop_cnt_r <= '0;
         ue_valid_r <= 1'b0;
         ue_addr_r  <= '0;
         irq_r      <= 1'b0;
      end else begin
         ce_cnt_r   <= ce_cnt_nxt_s;
         ue_cnt_r   <= ue_cnt_nxt_s;
         drop_cnt_r <= drop_cnt_nxt_s;
         ue_valid_r <= ue_valid_nxt_s;
         ue_addr_r  <= ue_addr_nxt_s;
         irq_r      <= irq_nxt_s;
      end
   end

   assign bus.wb_valid = !fifo_empty_s;
   assign bus.wb_addr  = head_s.addr;
   assign bus.wb_data  = head_s.data;
   assign ce_count     = ce_cnt_r;
   assign ue_count     = ue_cnt_r;
   assign drop_count   = drop_cnt_r;
   assign ue_valid     = ue_valid_r;
   assign ue_addr      = ue_addr_r;
   assign irq          = irq_r;

endmodule

// File: tb/tb_secded_scrub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_secded_scrub_ctrl
// Directed and randomized stimulus for secded_scrub_ctrl, checked against a
// queue-based behavioural model of the scrub controller.
// -----------------------------------------------------------------------------
module tb_secded_scrub_ctrl;
   import secded_scrub_ctrl_pkg::*;

   localparam int ADDR_W = 32;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 16;
   localparam int CMAX   = 65535;

   logic              clk = 1'b0;
   logic              rst;
   logic              clr;
   logic [CNT_W-1:0]  ce_count;
   logic [CNT_W-1:0]  ue_count;
   logic [CNT_W-1:0]  drop_count;
   logic              ue_valid;
   logic [ADDR_W-1:0] ue_addr;
   logic              irq;

   secded_scrub_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   secded_scrub_ctrl #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .ce_count   (ce_count),
      .ue_count   (ue_count),
      .drop_count (drop_count),
      .ue_valid   (ue_valid),
      .ue_addr    (ue_addr),
      .irq        (irq),
      .clr        (clr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   typedef struct {
      logic [31:0] a;
      logic [71:0] d;
   } ent_t;
   ent_t        q[$];
   int          m_ce, m_ue, m_drop;
   logic        m_uev;
   logic [31:0] m_uea;
   logic        m_irq;

   function automatic int sat(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply one clock edge worth of behaviour using the inputs present at the edge.
   task automatic model_step();
      bit   pop, is_ce, is_ue;
      ent_t e;
      if (rst) begin
         q.delete();
         m_ce = 0; m_ue = 0; m_drop = 0;
         m_uev = 1'b0; m_uea = 32'd0; m_irq = 1'b0;
         return;
      end
      pop   = (q.size() != 0) && bus.wb_ready;
      is_ue = bus.dec_valid && bus.double_error;
      is_ce = bus.dec_valid && bus.single_error && !bus.double_error;
      if (clr) begin
         m_ce = 0; m_ue = 0; m_drop = 0;
         m_uev = 1'b0; m_uea = 32'd0; m_irq = 1'b0;
      end
      if (pop) void'(q.pop_front());
      if (is_ce) begin
         m_ce = sat(m_ce);
         if (q.size() < DEPTH) begin
            e.a = bus.dec_addr;
            e.d = bus.dec_data;
            q.push_back(e);
         end else begin
            m_drop = sat(m_drop);
            m_irq  = 1'b1;
         end
      end
      if (is_ue) begin
         m_ue  = sat(m_ue);
         m_irq = 1'b1;
         if (!m_uev) begin
            m_uev = 1'b1;
            m_uea = bus.dec_addr;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".wb_valid"}, bus.wb_valid, (q.size() != 0));
      if (q.size() != 0) begin
         chk({tag, ".wb_addr"}, bus.wb_addr, q[0].a);
         chk({tag, ".wb_data"}, bus.wb_data, q[0].d);
      end
      chk({tag, ".ce_count"},   ce_count,   m_ce);
      chk({tag, ".ue_count"},   ue_count,   m_ue);
      chk({tag, ".drop_count"}, drop_count, m_drop);
      chk({tag, ".ue_valid"},   ue_valid,   m_uev);
      chk({tag, ".ue_addr"},    ue_addr,    m_uea);
      chk({tag, ".irq"},        irq,        m_irq);
   endtask

   task automatic step(input string tag, input bit do_check);
      @(posedge clk);
      model_step();
      #1;
      if (do_check) check_all(tag);
   endtask

   task automatic set_in(input bit dv, input bit se, input bit de,
                         input logic [31:0] a, input logic [71:0] d);
      bus.dec_valid    = dv;
      bus.single_error = se;
      bus.double_error = de;
      bus.dec_addr     = a;
      bus.dec_data     = d;
   endtask

   task automatic idle();
      set_in(1'b0, 1'b0, 1'b0, 32'd0, 72'd0);
      clr = 1'b0;
      rst = 1'b0;
   endtask

   initial begin
      logic [95:0] r;

      // Reset
      rst = 1'b1; clr = 1'b0; bus.wb_ready = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 32'd0, 72'd0);
      step("reset", 1'b0);
      step("reset", 1'b1);
      chk("reset.wb_valid", bus.wb_valid, 1'b0);
      chk("reset.wb_addr",  bus.wb_addr,  32'd0);
      chk("reset.wb_data",  bus.wb_data,  72'd0);
      chk("reset.ce_count", ce_count,     16'd0);
      chk("reset.irq",      irq,          1'b0);
      idle();

      // Single CE then pop
      set_in(1'b1, 1'b1, 1'b0, 32'h10, {9{8'hAB}});
      step("ce1", 1'b1);
      idle();
      chk("ce1.wb_valid", bus.wb_valid, 1'b1);
      chk("ce1.wb_addr",  bus.wb_addr,  32'h10);
      chk("ce1.wb_data",  bus.wb_data,  {9{8'hAB}});
      chk("ce1.ce_count", ce_count,     16'd1);
      chk("ce1.irq",      irq,          1'b0);
      bus.wb_ready = 1'b1;
      step("ce1pop", 1'b1);
      chk("ce1pop.wb_valid", bus.wb_valid, 1'b0);
      bus.wb_ready = 1'b0;

      // Overflow: five CEs into a four-entry FIFO
      for (int i = 1; i <= 5; i++) begin
         set_in(1'b1, 1'b1, 1'b0, i, {8'h00, 32'h0, i});
         step("ovf", 1'b1);
      end
      idle();
      chk("ovf.drop_count", drop_count, 16'd1);
      chk("ovf.irq",        irq,        1'b1);
      chk("ovf.head",       bus.wb_addr, 32'd1);

      // Full FIFO, CE with simultaneous pop is accepted
      bus.wb_ready = 1'b1;
      set_in(1'b1, 1'b1, 1'b0, 32'd9, 72'h99);
      step("fullpop", 1'b1);
      idle();
      bus.wb_ready = 1'b0;
      chk("fullpop.drop_count", drop_count, 16'd1);
      chk("fullpop.head",       bus.wb_addr, 32'd2);

      // Drain in order 2,3,4,9
      bus.wb_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step("drain", 1'b1);
      end
      chk("drain.wb_valid", bus.wb_valid, 1'b0);
      bus.wb_ready = 1'b0;

      // UE capture, clear, clear-vs-event
      clr = 1'b1;
      step("clr0", 1'b1);
      idle();
      set_in(1'b1, 1'b0, 1'b1, 32'h40, 72'd0);
      step("ue40", 1'b1);
      set_in(1'b1, 1'b0, 1'b1, 32'h80, 72'd0);
      step("ue80", 1'b1);
      idle();
      chk("ue.ue_count", ue_count, 16'd2);
      chk("ue.ue_addr",  ue_addr,  32'h40);
      chk("ue.ue_valid", ue_valid, 1'b1);
      chk("ue.irq",      irq,      1'b1);
      clr = 1'b1;
      step("clr1", 1'b1);
      idle();
      chk("clr1.ue_count", ue_count, 16'd0);
      chk("clr1.ue_valid", ue_valid, 1'b0);
      chk("clr1.ue_addr",  ue_addr,  32'd0);
      chk("clr1.irq",      irq,      1'b0);
      set_in(1'b1, 1'b0, 1'b1, 32'h80, 72'd0);
      clr = 1'b1;
      step("clrue", 1'b1);
      idle();
      chk("clrue.ue_count", ue_count, 16'd1);
      chk("clrue.ue_addr",  ue_addr,  32'h80);
      chk("clrue.ue_valid", ue_valid, 1'b1);

      // Both flags: UE only, no push; then flags without valid
      set_in(1'b1, 1'b1, 1'b1, 32'h55, 72'h55);
      step("both", 1'b1);
      chk("both.ue_count", ue_count,     16'd2);
      chk("both.ce_count", ce_count,     16'd0);
      chk("both.wb_valid", bus.wb_valid, 1'b0);
      set_in(1'b0, 1'b1, 1'b1, 32'h66, 72'h66);
      step("novalid", 1'b1);
      chk("novalid.ue_count", ue_count, 16'd2);
      idle();

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         r = {$urandom(), $urandom(), $urandom()};
         set_in(($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 4) == 0),
                $urandom(), r[71:0]);
         bus.wb_ready = ($urandom_range(0, 2) == 0);
         clr = ($urandom_range(0, 19) == 0);
         rst = ($urandom_range(0, 99) == 0);
         step("rand", 1'b1);
      end
      idle();

      // Saturation of ce_count
      clr = 1'b1;
      bus.wb_ready = 1'b1;
      step("satclr", 1'b1);
      clr = 1'b0;
      for (int i = 0; i < CMAX; i++) begin
         set_in(1'b1, 1'b1, 1'b0, i, 72'd0);
         step("satrun", 1'b0);
      end
      check_all("satmax");
      chk("satmax.ce_count", ce_count, 16'hFFFF);
      set_in(1'b1, 1'b1, 1'b0, 32'hABC, 72'd1);
      step("satover", 1'b1);
      chk("satover.ce_count", ce_count, 16'hFFFF);

      // Reset mid-stream with FIFO non-empty
      bus.wb_ready = 1'b0;
      set_in(1'b1, 1'b1, 1'b0, 32'h77, 72'h77);
      step("prerst", 1'b1);
      chk("prerst.wb_valid", bus.wb_valid, 1'b1);
      rst = 1'b1;
      set_in(1'b1, 1'b0, 1'b1, 32'h88, 72'h88);
      step("rst", 1'b1);
      idle();
      chk("rst.wb_valid",   bus.wb_valid, 1'b0);
      chk("rst.wb_addr",    bus.wb_addr,  32'd0);
      chk("rst.wb_data",    bus.wb_data,  72'd0);
      chk("rst.ce_count",   ce_count,     16'd0);
      chk("rst.ue_count",   ue_count,     16'd0);
      chk("rst.drop_count", drop_count,   16'd0);
      chk("rst.ue_valid",   ue_valid,     1'b0);
      chk("rst.ue_addr",    ue_addr,      32'd0);
      chk("rst.irq",        irq,          1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/secded_scrub_ctrl.md
# secded_scrub_ctrl

Sequential error-handling stage directly downstream of the sequential SECDED decoder. Per decoded word it takes the registered flags (`single_error`, `double_error`) and the corrected 72-bit codeword. Single-bit-corrected words are queued as scrub write-back requests toward the memory controller. Correctable and uncorrectable events are counted, and the first uncorrectable address is captured and raised as an interrupt.

## Interface
Parameters:
- `ADDR_W`, 32, width of word address.
- `DEPTH`, 4, scrub FIFO entries; power of two, ≥2.
- `CNT_W`, 16, width of event counters.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `dec_valid`  in  1  decoder outputs valid this cycle.
- `dec_addr`  in  ADDR_W  address of the word, aligned with the decoder outputs.
- `dec_data`  in  72  corrected codeword, parity in [71:64].
- `single_error`  in  1  decoder single-bit error flag.
- `double_error`  in  1  decoder double-bit error flag.
- `wb_valid`  out  1  scrub write request pending.
- `wb_ready`  in  1  memory controller accepts the request.
- `wb_addr`  out  ADDR_W  scrub address.
- `wb_data`  out  72  corrected codeword to rewrite.
- `ce_count`  out  CNT_W  correctable events, saturating.
- `ue_count`  out  CNT_W  uncorrectable events, saturating.
- `drop_count`  out  CNT_W  scrubs dropped on full FIFO, saturating.
- `ue_valid`  out  1  `ue_addr` holds a captured address.
- `ue_addr`  out  ADDR_W  address of the first UE since the last clear.
- `irq`  out  1  level interrupt; set on any UE or drop.
- `clr`  in  1  clears counters, `ue_valid`, `ue_addr` and `irq`.

## Operation
- Event classification applies only when `dec_valid`=1:
  - CE: `single_error`=1 and `double_error`=0.
  - UE: `double_error`=1. UE has priority if both flags are set.
  - No error: both flags 0. Nothing happens.
- On CE:
  - `ce_count` increments.
  - {`dec_addr`, `dec_data`} is pushed to the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the entry is dropped, `drop_count` increments and `irq` sets.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted.
- On UE:
  - `ue_count` increments and `irq` sets.
  - If `ue_valid`=0, `ue_addr` ← `dec_addr` and `ue_valid` ← 1.
  - If `ue_valid`=1, `ue_addr` is held.
  - Nothing is pushed to the FIFO, because the data is not correctable.
- FIFO:
  - `wb_valid` equals not-empty. `wb_addr` and `wb_data` show the head entry.
  - A pop happens when `wb_valid` and `wb_ready` are both 1.
  - The head stays stable while `wb_valid`=1 and `wb_ready`=0.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally. The extra MSB distinguishes full from empty.
- Counters stick at 2^CNT_W−1 and do not wrap.
- `clr`:
  - Zeroes all three counters, `ue_valid`, `ue_addr` and `irq`.
  - Does not touch FIFO contents.
  - If an event arrives in the same cycle as `clr`, the event wins over the clear. The affected counter becomes 1, and a UE recaptures `ue_addr` and sets `ue_valid`.
- `rst`: FIFO emptied, all counters 0, `ue_valid`/`ue_addr`/`irq`/`wb_valid` 0. Reset has priority over every input, and any in-flight write-back request is abandoned.

## Timing
- All outputs are registered. Reset values: all outputs 0.
- CE push at edge N: `wb_valid` is 1 after edge N, so a bench sees it at cycle N+1.
- Counters, `ue_*` and `irq` update on the same edge that samples the event, with 1-cycle latency.
- A pop at edge N exposes the next entry, or deasserts `wb_valid`, after edge N.
- Throughput is one push and one pop per cycle.
- The input side has no backpressure: `dec_valid` is never stalled, and overflow drops the entry.

## Structure
- Add to `SECDED_ECC_pkg`:
  - `scrub_entry_t`, a packed struct {addr, data[71:0]}, with ADDR_W taken as a package constant `SCRUB_ADDR_W`.
  - Event enum `ecc_evt_e` {EVT_NONE, EVT_CE, EVT_UE}.
- Sub-module `secded_scrub_fifo`: parameterised synchronous FIFO, DEPTH × `scrub_entry_t`, with push/pop/full/empty.
- The counter, capture and irq logic lives in the top module.

## Test plan
- Reset, then CE at addr 0x10 with data 0xAB..: `wb_valid`=1 next cycle, `wb_addr`=0x10, `ce_count`=1, `irq`=0. Pop with `wb_ready`=1, then `wb_valid`=0.
- `wb_ready`=0 and 5 CEs at addrs 1–5 with DEPTH=4: FIFO holds 1–4, `drop_count`=1, `irq`=1. Draining returns 1, 2, 3, 4 in order.
- FIFO full, CE at addr 9 with `wb_ready`=1 in the same cycle: push accepted, `drop_count` unchanged, next head is 2.
- UE at 0x40, then UE at 0x80: `ue_count`=2, `ue_addr`=0x40, `ue_valid`=1, `irq`=1. Pulse `clr`, then all zero. UE at 0x80 in the same cycle as `clr`: `ue_count`=1, `ue_addr`=0x80.
- Both flags set with `dec_valid`=1: counts as UE only, no push. `dec_valid`=0 with flags set: no effect.
- Force `ce_count` to 0xFFFF via 65535 CEs, then one more CE: count stays 0xFFFF. Assert `rst` mid-stream with the FIFO non-empty: all outputs 0 on the next cycle.
